// File: rtl/dp_responder.sv
// rtl/dp_responder.sv - start/finished instruction responder driving frame-buffer writes and weight reads
module dp_responder #(
  parameter int SCREEN_WIDTH      = 160,
  parameter int SCREEN_HEIGHT     = 120,
  parameter int X_WIDTH           = 8,
  parameter int Y_WIDTH           = 7,
  parameter int ADDR_WIDTH        = 15,
  parameter int COLOR_WIDTH       = 3,
  parameter int OPCODE_WIDTH      = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_DRAW      = 1,
  parameter logic [OPCODE_WIDTH-1:0] OP_NNMEMREAD = 2,
  parameter logic [OPCODE_WIDTH-1:0] OP_CLEAR     = 3,
  parameter int DATA_WIDTH        = 16,
  parameter int NUM_WEIGHTS       = 8,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 32
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              start,
  input  logic [INSTRUCTION_WIDTH-1:0]      instruction,
  output logic                              finished,
  output logic [RESULT_WIDTH-1:0]           result,
  input  logic [DATA_WIDTH*NUM_WEIGHTS-1:0] weights,
  output logic                              fb_we,
  output logic [ADDR_WIDTH-1:0]             fb_addr,
  output logic [COLOR_WIDTH-1:0]            fb_color
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR_LOOP} state_t;

  localparam int IDX_WIDTH = 6;
  localparam int FB_SIZE   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int X_LSB     = OPCODE_WIDTH;
  localparam int Y_LSB     = X_LSB + X_WIDTH;
  localparam int C_LSB     = Y_LSB + Y_WIDTH;
  localparam int EN_BIT    = C_LSB + COLOR_WIDTH;
  localparam int USED_W    = EN_BIT + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);

  state_t                         state, state_d;
  logic                           armed, armed_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic                           finished_d;
  logic [RESULT_WIDTH-1:0]        result_d;
  logic                           fb_we_d;
  logic [ADDR_WIDTH-1:0]          fb_addr_d;
  logic [COLOR_WIDTH-1:0]         fb_color_d;

  logic [OPCODE_WIDTH-1:0]        opcode;
  logic [X_WIDTH-1:0]             x_field;
  logic [Y_WIDTH-1:0]             y_field;
  logic [COLOR_WIDTH-1:0]         color_field;
  logic                           en_field;
  logic [IDX_WIDTH-1:0]           idx_field;
  logic                           in_range;
  logic                           idx_ok;
  logic [ADDR_WIDTH-1:0]          draw_addr;
  logic [DATA_WIDTH-1:0]          weight_sel;
  logic                           unused_bits;

  assign opcode      = instr_q[OPCODE_WIDTH-1:0];
  assign x_field     = instr_q[X_LSB +: X_WIDTH];
  assign y_field     = instr_q[Y_LSB +: Y_WIDTH];
  assign color_field = instr_q[C_LSB +: COLOR_WIDTH];
  assign en_field    = instr_q[EN_BIT];
  assign idx_field   = instr_q[OPCODE_WIDTH +: IDX_WIDTH];
  assign unused_bits = ^instr_q[INSTRUCTION_WIDTH-1:USED_W];

  assign in_range  = (int'(x_field) < SCREEN_WIDTH) && (int'(y_field) < SCREEN_HEIGHT);
  assign idx_ok    = int'(idx_field) < NUM_WEIGHTS;
  assign draw_addr = ADDR_WIDTH'(y_field) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(x_field);

  // Pick the addressed weight off the flat bus; out-of-range indices select zero.
  always_comb begin
    weight_sel = '0;
    for (int i = 0; i < NUM_WEIGHTS; i++) begin
      if (int'(idx_field) == i) weight_sel = weights[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State and registered outputs; every output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      armed    <= 1'b1;
      instr_q  <= '0;
      finished <= 1'b1;
      result   <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_color <= '0;
    end else begin
      state    <= state_d;
      armed    <= armed_d;
      instr_q  <= instr_d;
      finished <= finished_d;
      result   <= result_d;
      fb_we    <= fb_we_d;
      fb_addr  <= fb_addr_d;
      fb_color <= fb_color_d;
    end
  end

  // Next-state and next-output decode; during a clear fb_addr doubles as the fill counter.
  always_comb begin
    state_d    = state;
    armed_d    = armed | ~start;
    instr_d    = instr_q;
    finished_d = finished;
    result_d   = result;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr;
    fb_color_d = fb_color;
    case (state)
      IDLE: begin
        if (start && armed) begin
          instr_d    = instruction;
          finished_d = 1'b0;
          armed_d    = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d    = IDLE;
        finished_d = 1'b1;
        case (opcode)
          OP_DRAW: begin
            if (!en_field) begin
              result_d = '0;
            end else if (in_range) begin
              fb_we_d    = 1'b1;
              fb_addr_d  = draw_addr;
              fb_color_d = color_field;
              result_d   = '0;
            end else begin
              result_d = RESULT_WIDTH'(1);
            end
          end
          OP_NNMEMREAD: begin
            result_d = idx_ok ? {{(RESULT_WIDTH-DATA_WIDTH){weight_sel[DATA_WIDTH-1]}}, weight_sel}
                              : '0;
          end
          OP_CLEAR: begin
            // First fill write is issued here so address 0 appears the cycle after EXEC.
            fb_we_d    = 1'b1;
            fb_addr_d  = '0;
            fb_color_d = color_field;
            finished_d = 1'b0;
            state_d    = CLEAR_LOOP;
          end
          default: result_d = '1;
        endcase
      end
      CLEAR_LOOP: begin
        if (fb_addr == LAST_ADDR) begin
          state_d    = IDLE;
          finished_d = 1'b1;
          result_d   = RESULT_WIDTH'(FB_SIZE);
        end else begin
          fb_we_d    = 1'b1;
          fb_addr_d  = fb_addr + ADDR_WIDTH'(1);
          fb_color_d = color_field;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_responder.sv
// tb/tb_dp_responder.sv - scoreboard bench for dp_responder
module tb_dp_responder;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  instruction = '0;
  logic         finished;
  logic [31:0]  result;
  logic [127:0] weights;
  logic         fb_we;
  logic [14:0]  fb_addr;
  logic [2:0]   fb_color;

  int checks = 0;
  int errors = 0;

  logic [17:0] wq[$];
  logic [31:0] rq[$];
  logic        fin_prev = 1'b1;

  dp_responder dut (
    .clock(clock), .resetn(resetn), .start(start), .instruction(instruction),
    .finished(finished), .result(result), .weights(weights),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_color(fb_color)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_draw(input int x, input int y, input int c, input int en);
    return {9'b0, 1'(en), 3'(c), 7'(y), 8'(x), 4'd1};
  endfunction

  function automatic logic [31:0] mk_nn(input int idx);
    return {22'b0, 6'(idx), 4'd2};
  endfunction

  function automatic logic [31:0] mk_clear(input int c);
    return {9'b0, 1'b0, 3'(c), 7'b0, 8'b0, 4'd3};
  endfunction

  // Monitor: compare every write and every completion against the scoreboard queues.
  always @(negedge clock) begin
    logic [17:0] ew;
    logic [31:0] er;
    if (fb_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%0d actual_color=%0d expected=none", fb_addr, fb_color);
      end else begin
        ew = wq.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(ew[17:3]));
        chk("wr_color", 32'(fb_color), 32'(ew[2:0]));
      end
    end
    if (finished === 1'b1 && fin_prev === 1'b0) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish actual_result=%h expected=none", result);
      end else begin
        er = rq.pop_front();
        chk("result", result, er);
      end
    end
    fin_prev = finished;
  end

  // One short instruction (DRAW/NNMEMREAD/unknown) with start held for 'hold' cycles.
  task automatic do_short(input logic [31:0] ins, input bit exp_we, input int waddr,
                          input int wcolor, input logic [31:0] exp_res, input int hold);
    if (exp_we) wq.push_back({15'(waddr), 3'(wcolor)});
    rq.push_back(exp_res);
    @(posedge clock); #1;
    instruction = ins;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("accept_fin_low", 32'(finished), 32'd0);
    chk("accept_no_we", 32'(fb_we), 32'd0);
    @(posedge clock); #1;
    if (hold == 2) start = 1'b0;
    @(negedge clock);
    chk("done_fin_a2", 32'(finished), 32'd1);
    chk("done_we_a2", 32'(fb_we), 32'(exp_we));
    for (int i = 2; i < hold; i++) begin
      @(posedge clock); #1;
      if (i == hold - 1) start = 1'b0;
      @(negedge clock);
      chk("held_no_retrigger_fin", 32'(finished), 32'd1);
      chk("held_no_retrigger_we", 32'(fb_we), 32'd0);
    end
  endtask

  // CLEAR, optionally interrupted by reset while address reset_at is on the bus.
  task automatic do_clear(input int color, input int reset_at);
    int  last;
    int  k;
    bit  done;
    last = (reset_at < 0) ? 19199 : reset_at;
    for (int a = 0; a <= last; a++) wq.push_back({15'(a), 3'(color)});
    rq.push_back((reset_at < 0) ? 32'd19200 : 32'd0);
    @(posedge clock); #1;
    instruction = mk_clear(color);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("clr_accept_fin_low", 32'(finished), 32'd0);
    @(posedge clock); #1;
    start = 1'b0;
    k = 2;
    done = 1'b0;
    @(negedge clock);
    chk("clr_first_we", 32'(fb_we), 32'd1);
    while (!done && k < 20000) begin
      if (reset_at >= 0 && fb_we === 1'b1 && int'(fb_addr) == reset_at) begin
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_fin", 32'(finished), 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        done = 1'b1;
      end else if (finished === 1'b1) begin
        chk("clr_fin_cycle", 32'(k), 32'd19202);
        done = 1'b1;
      end else begin
        @(negedge clock);
        k++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL clr_timeout actual_cycles=%0d expected=finish", k);
    end
  endtask

  initial begin
    weights = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'hFFF6, 16'h2222, 16'h1234, 16'h0011};
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_fin", 32'(finished), 32'd1);
    chk("reset_result", result, 32'd0);
    chk("reset_we", 32'(fb_we), 32'd0);
    chk("reset_addr", 32'(fb_addr), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;

    do_short(mk_draw(5, 2, 6, 1), 1'b1, 325, 6, 32'd0, 2);
    do_short(mk_draw(160, 0, 1, 1), 1'b0, 0, 0, 32'd1, 2);
    do_short(mk_draw(3, 3, 5, 0), 1'b0, 0, 0, 32'd0, 2);
    chk("hold_addr", 32'(fb_addr), 32'd325);
    chk("hold_color", 32'(fb_color), 32'd6);
    do_short(mk_draw(159, 119, 7, 1), 1'b1, 19199, 7, 32'd0, 2);
    do_short(mk_draw(0, 120, 2, 1), 1'b0, 0, 0, 32'd1, 2);

    do_short(mk_nn(3), 1'b0, 0, 0, 32'hFFFF_FFF6, 2);
    do_short(mk_nn(9), 1'b0, 0, 0, 32'h0000_0000, 2);
    do_short(mk_nn(1), 1'b0, 0, 0, 32'h0000_1234, 2);
    do_short(32'h0000_0007, 1'b0, 0, 0, 32'hFFFF_FFFF, 2);

    do_clear(2, -1);

    do_short(mk_draw(1, 0, 4, 1), 1'b1, 1, 4, 32'd0, 5);
    do_short(mk_draw(2, 0, 3, 1), 1'b1, 2, 3, 32'd0, 2);

    do_clear(5, 100);
    do_short(mk_draw(0, 1, 1, 1), 1'b1, 160, 1, 32'd0, 2);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_responder.md
# dp_responder

Datapath-side responder for the start/instruction/finished/result handshake used by the controller FSMs such as the frame-buffer display sequencer. It accepts one instruction per handshake and decodes it. DRAW writes one pixel to the frame-buffer write port. CLEAR fills the whole frame buffer. NNMEMREAD returns one weight from the flat neural-net weight bus. The block sits between the controller FSMs and the VGA frame-buffer memory.

## Interface
- SCREEN_WIDTH, 160, pixels per row
- SCREEN_HEIGHT, 120, rows
- X_WIDTH, 8, x field width
- Y_WIDTH, 7, y field width
- ADDR_WIDTH, 15, frame-buffer address width
- COLOR_WIDTH, 3, pixel colour width
- OPCODE_WIDTH, 4, opcode field width
- OP_DRAW / OP_NNMEMREAD / OP_CLEAR, 1 / 2 / 3, opcode values; top level overrides them with the shared constants-header values
- DATA_WIDTH, 16, width of one weight (signed)
- NUM_WEIGHTS, 8, weights on the flat bus
- INSTRUCTION_WIDTH, 32; RESULT_WIDTH, 32

Ports:
- clock  in  1  clock; all logic on posedge
- resetn  in  1  synchronous, active-low reset
- start  in  1  request from initiator
- instruction  in  INSTRUCTION_WIDTH  instruction word; sampled only on acceptance
- finished  out  1  1 = idle, result valid
- result  out  RESULT_WIDTH  result of last instruction
- weights  in  DATA_WIDTH*NUM_WEIGHTS  flat weight bus; weight i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  ADDR_WIDTH  write address
- fb_color  out  COLOR_WIDTH  write data

## Operation
- Instruction fields, LSB first:
  - opcode at [OPCODE_WIDTH-1:0].
  - DRAW: x, then y, then color, then enable. Defaults: x [11:4], y [18:12], color [21:19], en [22].
  - CLEAR: uses the same color field.
  - NNMEMREAD: index at [OPCODE_WIDTH+5:OPCODE_WIDTH].
- States: IDLE, EXEC, CLEAR_LOOP.
- Acceptance:
  - Occurs in IDLE when start=1 and armed=1.
  - Latches instruction, clears finished and armed, and moves to EXEC.
  - armed sets on any cycle where start=0. This prevents a start held high across DELAY from re-triggering.
  - start is ignored outside IDLE.
- EXEC, DRAW:
  - en=1 and x<SCREEN_WIDTH and y<SCREEN_HEIGHT: fb_we=1 for one cycle, fb_addr = y*SCREEN_WIDTH + x (ADDR_WIDTH bits), fb_color = color, result=0.
  - en=0: no write, result=0.
  - Out of range: no write, result=1.
  - Go to IDLE with finished=1.
- EXEC, NNMEMREAD:
  - index<NUM_WEIGHTS: result = weight[index] sign-extended to RESULT_WIDTH.
  - Otherwise result = 0 and no effect.
  - Go to IDLE.
- EXEC, CLEAR: load counter=0 and go to CLEAR_LOOP.
- CLEAR_LOOP:
  - One write per cycle: fb_we=1, fb_addr=counter, fb_color=color.
  - After address SCREEN_WIDTH*SCREEN_HEIGHT-1: result = SCREEN_WIDTH*SCREEN_HEIGHT (19200), go to IDLE, finished=1.
- Unknown opcode: result = all ones, no write, go to IDLE.
- result holds until the next instruction completes. It is not changed on acceptance.
- fb_addr and fb_color hold their last values when fb_we=0.

## Timing
- All outputs registered.
- Reset values: finished=1, result=0, fb_we=0, fb_addr=0, fb_color=0, state IDLE, armed=1.
- Accept edge at end of cycle A: finished=0 from cycle A+1.
- DRAW, NNMEMREAD, unknown: finished=1 and result valid in cycle A+2. For DRAW, fb_we=1 in exactly cycle A+2.
- CLEAR: fb_we=1 in cycles A+2 through A+1+19200, with addresses 0 through 19199 ascending. finished=1 in cycle A+2+19200.
- Initiator contract: start high two cycles, then low while polling finished. finished is guaranteed 0 by the cycle start first reads low, so a stale finished=1 is never observed.
- Reset mid-operation (including mid-CLEAR): outputs return to reset values on that edge, the write stream stops, and the instruction is discarded.
- start=1 on the same edge that finished rises: not accepted unless armed=1. Normal initiators already dropped start, so armed=1.

## Test plan
- Reset with start=0: finished=1, result=0, fb_we=0. Then DRAW x=5, y=2, color=6, en=1 -> one fb_we pulse, fb_addr=325, fb_color=6, finished at A+2, result=0.
- DRAW x=160, y=0, en=1 -> no fb_we, result=1. DRAW en=0 -> no fb_we, result=0.
- NNMEMREAD index 3 with weight[3]=16'hFFF6 -> result=32'hFFFFFFF6. Index 9 -> result=0.
- CLEAR color=2 -> 19200 consecutive fb_we cycles, addresses 0..19199, fb_color=2 throughout, result=19200, finished at A+19202.
- start held high for 5 cycles -> exactly one acceptance; a second instruction is accepted only after start goes low and returns high.
- resetn=0 during CLEAR at address 100 -> next cycle fb_we=0, finished=1, result=0. A following DRAW executes normally.
